// File: rtl/fiber_mem_arb_pkg.sv
// rtl/fiber_mem_arb_pkg.sv - shared types and constants for the fiber SRAM port arbiter
package fiber_mem_arb_pkg;

   localparam int RSP_DEPTH = 2;
   localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

   typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_t;
   typedef enum logic {PREF_WR, PREF_RD} pref_t;

endpackage

// File: rtl/fiber_mem_arb_rsp_fifo.sv
// rtl/fiber_mem_arb_rsp_fifo.sv - 2-entry first-word-fall-through read response buffer
module fiber_mem_arb_rsp_fifo
   import fiber_mem_arb_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en_i,
   input  logic                 flush_i,
   input  logic                 push_i,
   input  logic [DATA_W-1:0]    push_data_i,
   input  logic                 pop_i,
   output logic [DATA_W-1:0]    head_data_o,
   output logic                 head_valid_o,
   output logic [RSP_CNT_W-1:0] count_o
);

   logic [DATA_W-1:0]    mem_q [RSP_DEPTH];
   logic                 rd_ptr_q;
   logic                 wr_ptr_q;
   logic [RSP_CNT_W-1:0] count_q;
   logic                 do_push;
   logic                 do_pop;

   assign do_push = clk_en_i & ~flush_i & push_i;
   assign do_pop  = clk_en_i & ~flush_i & pop_i & (count_q != '0);

   assign head_valid_o = (count_q != '0);
   assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o      = count_q;

   // Storage, pointers and occupancy; flush clears like reset even when clk_en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (clk_en_i) begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + RSP_CNT_W'(do_push) - RSP_CNT_W'(do_pop);
      end
   end

   // The arbiter's credit check must keep a push from ever landing on a full buffer
   assert property (@(posedge clk) disable iff (rst)
                    (do_push && !do_pop) |-> (count_q < RSP_CNT_W'(RSP_DEPTH)));

endmodule

// File: rtl/fiber_mem_port_arbiter.sv
// rtl/fiber_mem_port_arbiter.sv - write/read arbiter for the single-port fiber tile SRAM
module fiber_mem_port_arbiter
   import fiber_mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 64,
   parameter int MAX_WR_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              wr_req_valid,
   input  logic [ADDR_W-1:0] wr_req_addr,
   input  logic [DATA_W-1:0] wr_req_data,
   output logic              wr_req_ready,
   input  logic              rd_req_valid,
   input  logic [ADDR_W-1:0] rd_req_addr,
   output logic              rd_req_ready,
   output logic [DATA_W-1:0] rd_rsp_data,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [ADDR_W-1:0] addr_to_mem,
   output logic [DATA_W-1:0] data_to_mem,
   output logic              wen_to_mem,
   output logic              ren_to_mem,
   input  logic [DATA_W-1:0] data_from_mem,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_WR_BURST) + 1;

   grant_t               grant;
   pref_t                pref_q;
   logic [CNT_W-1:0]     wr_cnt_q;
   logic                 inflight_q;
   logic [RSP_CNT_W-1:0] buf_count;
   logic [RSP_CNT_W-1:0] occ;
   logic                 arb_ok;
   logic                 rsp_pop;
   logic                 rd_el;
   logic                 wr_el;

   // A read may only issue if its response is guaranteed a buffer slot
   assign arb_ok  = clk_en & ~flush & ~rst;
   assign occ     = buf_count + RSP_CNT_W'(inflight_q);
   assign rsp_pop = rd_rsp_valid & rd_rsp_ready & clk_en;
   assign rd_el   = rd_req_valid & arb_ok &
                    ((occ < RSP_CNT_W'(RSP_DEPTH)) |
                     ((occ == RSP_CNT_W'(RSP_DEPTH)) & (buf_count != '0) & rd_rsp_valid & rd_rsp_ready));
   assign wr_el   = wr_req_valid & arb_ok;

   // Pick at most one requester; the preference only matters under contention
   always_comb begin
      grant = GNT_NONE;
      if (wr_el && rd_el) begin
         if (pref_q == PREF_RD) grant = GNT_RD;
         else                   grant = GNT_WR;
      end else if (wr_el) begin
         grant = GNT_WR;
      end else if (rd_el) begin
         grant = GNT_RD;
      end
   end

   assign wr_req_ready = (grant == GNT_WR);
   assign rd_req_ready = (grant == GNT_RD);

   // Steer the granted request onto the SRAM port; idle cycles drive zeros
   always_comb begin
      addr_to_mem = '0;
      data_to_mem = '0;
      wen_to_mem  = 1'b0;
      ren_to_mem  = 1'b0;
      case (grant)
         GNT_WR: begin
            wen_to_mem  = 1'b1;
            addr_to_mem = wr_req_addr;
            data_to_mem = wr_req_data;
         end
         GNT_RD: begin
            ren_to_mem  = 1'b1;
            addr_to_mem = rd_req_addr;
         end
         default: ;
      endcase
   end

   // Write-burst fairness state and the one-cycle SRAM read pipeline flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pref_q     <= PREF_WR;
         wr_cnt_q   <= '0;
         inflight_q <= 1'b0;
      end else if (flush) begin
         pref_q     <= PREF_WR;
         wr_cnt_q   <= '0;
         inflight_q <= 1'b0;
      end else if (clk_en) begin
         inflight_q <= ren_to_mem;
         case (grant)
            GNT_WR: begin
               if (wr_cnt_q == CNT_W'(MAX_WR_BURST - 1)) begin
                  pref_q   <= PREF_RD;
                  wr_cnt_q <= '0;
               end else begin
                  wr_cnt_q <= wr_cnt_q + CNT_W'(1);
               end
            end
            GNT_RD: begin
               pref_q   <= PREF_WR;
               wr_cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   fiber_mem_arb_rsp_fifo #(
      .DATA_W(DATA_W)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst         (rst),
      .clk_en_i    (clk_en),
      .flush_i     (flush),
      .push_i      (inflight_q),
      .push_data_i (data_from_mem),
      .pop_i       (rsp_pop),
      .head_data_o (rd_rsp_data),
      .head_valid_o(rd_rsp_valid),
      .count_o     (buf_count)
   );

   assign busy = inflight_q | (buf_count != '0);

endmodule

// File: tb/tb_fiber_mem_port_arbiter.sv
// tb/tb_fiber_mem_port_arbiter.sv - directed self-checking bench for fiber_mem_port_arbiter
module tb_fiber_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        flush;
   logic        wr_req_valid;
   logic [8:0]  wr_req_addr;
   logic [63:0] wr_req_data;
   logic        wr_req_ready;
   logic        rd_req_valid;
   logic [8:0]  rd_req_addr;
   logic        rd_req_ready;
   logic [63:0] rd_rsp_data;
   logic        rd_rsp_valid;
   logic        rd_rsp_ready;
   logic [8:0]  addr_to_mem;
   logic [63:0] data_to_mem;
   logic        wen_to_mem;
   logic        ren_to_mem;
   logic [63:0] data_from_mem;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [63:0] sram [512];

   always #5 clk = ~clk;

   fiber_mem_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .flush        (flush),
      .wr_req_valid (wr_req_valid),
      .wr_req_addr  (wr_req_addr),
      .wr_req_data  (wr_req_data),
      .wr_req_ready (wr_req_ready),
      .rd_req_valid (rd_req_valid),
      .rd_req_addr  (rd_req_addr),
      .rd_req_ready (rd_req_ready),
      .rd_rsp_data  (rd_rsp_data),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .addr_to_mem  (addr_to_mem),
      .data_to_mem  (data_to_mem),
      .wen_to_mem   (wen_to_mem),
      .ren_to_mem   (ren_to_mem),
      .data_from_mem(data_from_mem),
      .busy         (busy)
   );

   // SRAM model: one-cycle read latency
   always @(posedge clk) begin
      if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
      if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic idle;
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      wr_req_addr  = '0;
      wr_req_data  = '0;
      rd_req_addr  = '0;
   endtask

   task automatic both(input logic [8:0] waddr, input logic [63:0] wdata, input logic [8:0] raddr);
      wr_req_valid = 1'b1;
      wr_req_addr  = waddr;
      wr_req_data  = wdata;
      rd_req_valid = 1'b1;
      rd_req_addr  = raddr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int issued;
      int rx;
      for (int i = 0; i < 512; i++) sram[i] = '0;
      data_from_mem = '0;
      rst = 1'b1;
      clk_en = 1'b1;
      flush = 1'b0;
      rd_rsp_ready = 1'b0;
      idle();
      both(9'd1, 64'h11, 9'd2);

      // Reset: requests present but everything stays quiet
      settle();
      chk("rst_wr_ready", wr_req_ready, 0);
      chk("rst_rd_ready", rd_req_ready, 0);
      chk("rst_wen", wen_to_mem, 0);
      chk("rst_ren", ren_to_mem, 0);
      chk("rst_addr", addr_to_mem, 0);
      chk("rst_data", data_to_mem, 0);
      chk("rst_rsp_valid", rd_rsp_valid, 0);
      chk("rst_busy", busy, 0);
      idle();
      @(posedge clk);
      #1 rst = 1'b0;

      // Six lone writes: 0..5 <- A0..A5
      for (int i = 0; i < 6; i++) begin
         wr_req_valid = 1'b1;
         wr_req_addr  = 9'(i);
         wr_req_data  = 64'hA0 + 64'(i);
         settle();
         chk("wr_ready", wr_req_ready, 1);
         chk("wr_wen", wen_to_mem, 1);
         chk("wr_ren", ren_to_mem, 0);
         chk("wr_addr", addr_to_mem, 64'(i));
         chk("wr_data", data_to_mem, 64'hA0 + 64'(i));
         tick();
      end
      idle();

      // Burst of 4 wrapped: pref is now RD, so the read wins contention
      rd_rsp_ready = 1'b1;
      both(9'd7, 64'h77, 9'd3);
      settle();
      chk("raw_rd_ready", rd_req_ready, 1);
      chk("raw_wr_ready", wr_req_ready, 0);
      chk("raw_ren", ren_to_mem, 1);
      chk("raw_wen", wen_to_mem, 0);
      chk("raw_addr", addr_to_mem, 3);
      chk("raw_data0", data_to_mem, 0);
      tick();
      idle();
      settle();
      chk("raw_n1_valid", rd_rsp_valid, 0);
      chk("raw_n1_busy", busy, 1);
      tick();
      settle();
      chk("raw_n2_valid", rd_rsp_valid, 1);
      chk("raw_n2_data", rd_rsp_data, 64'hA3);
      chk("raw_n2_busy", busy, 1);
      tick();
      settle();
      chk("raw_n3_busy", busy, 0);
      chk("raw_n3_valid", rd_rsp_valid, 0);
      tick();

      // Contention: W,W,W,W,R repeated
      for (int i = 0; i < 10; i++) begin
         both(9'd100 + 9'(i), 64'(i), 9'd0);
         settle();
         chk("cont_rd", rd_req_ready, (i % 5 == 4) ? 1 : 0);
         chk("cont_wr", wr_req_ready, (i % 5 == 4) ? 0 : 1);
         tick();
      end
      idle();
      tick();
      tick();
      tick();
      settle();
      chk("cont_drain_busy", busy, 0);
      tick();

      // Backpressure: only two reads fit while the sink stalls
      issued = 0;
      rx = 0;
      for (int c = 0; c < 17; c++) begin
         rd_req_valid = (issued < 4);
         rd_req_addr  = 9'(issued);
         rd_rsp_ready = (c >= 5);
         if (c == 5) chk("bp_held_grants", 64'(issued), 2);
         settle();
         if (c < 5) chk("bp_ready", rd_req_ready, (c < 2) ? 1 : 0);
         if (c == 4) chk("bp_held_valid", rd_rsp_valid, 1);
         if (rd_req_valid && rd_req_ready) issued++;
         if (rd_rsp_valid && rd_rsp_ready) begin
            chk("bp_order", rd_rsp_data, 64'hA0 + 64'(rx));
            rx++;
         end
         tick();
      end
      idle();
      chk("bp_issued", 64'(issued), 4);
      chk("bp_received", 64'(rx), 4);
      settle();
      chk("bp_busy", busy, 0);
      tick();

      // Flush resets pref: four writes set pref=RD, flush, then write wins
      for (int i = 0; i < 4; i++) begin
         wr_req_valid = 1'b1;
         wr_req_addr  = 9'd300 + 9'(i);
         wr_req_data  = 64'h300 + 64'(i);
         tick();
      end
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      both(9'd310, 64'h310, 9'd0);
      settle();
      chk("flush_pref_wr", wr_req_ready, 1);
      tick();
      idle();

      // Flush with a read in flight discards it
      rd_req_valid = 1'b1;
      rd_req_addr  = 9'd5;
      settle();
      chk("fl_rd_grant", rd_req_ready, 1);
      tick();
      flush = 1'b1;
      both(9'd311, 64'h311, 9'd0);
      settle();
      chk("fl_wr_ready", wr_req_ready, 0);
      chk("fl_rd_ready", rd_req_ready, 0);
      chk("fl_ren", ren_to_mem, 0);
      tick();
      flush = 1'b0;
      settle();
      chk("fl_valid", rd_rsp_valid, 0);
      chk("fl_busy", busy, 0);
      chk("fl_next_wr", wr_req_ready, 1);
      tick();
      idle();
      settle();
      chk("fl_valid_late", rd_rsp_valid, 0);
      tick();

      // clk_en freeze with one buffered response and wr_cnt=3
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_req_addr  = 9'd1;
      settle();
      chk("ce_rd_grant", rd_req_ready, 1);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         wr_req_valid = 1'b1;
         wr_req_addr  = 9'd200 + 9'(i);
         wr_req_data  = 64'h200 + 64'(i);
         tick();
      end
      clk_en = 1'b0;
      rd_rsp_ready = 1'b1;
      both(9'd210, 64'h210, 9'd2);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("ce_wr_ready", wr_req_ready, 0);
         chk("ce_rd_ready", rd_req_ready, 0);
         chk("ce_wen", wen_to_mem, 0);
         chk("ce_ren", ren_to_mem, 0);
         chk("ce_valid", rd_rsp_valid, 1);
         tick();
      end
      clk_en = 1'b1;
      rd_rsp_ready = 1'b0;
      settle();
      chk("ce_resume_wr", wr_req_ready, 1);
      tick();
      settle();
      chk("ce_resume_rd", rd_req_ready, 1);
      chk("ce_resume_addr", addr_to_mem, 2);
      tick();
      idle();
      rd_rsp_ready = 1'b1;
      settle();
      chk("ce_head0_valid", rd_rsp_valid, 1);
      chk("ce_head0_data", rd_rsp_data, 64'hA1);
      tick();
      settle();
      chk("ce_head1_valid", rd_rsp_valid, 1);
      chk("ce_head1_data", rd_rsp_data, 64'hA2);
      tick();
      settle();
      chk("ce_end_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fiber_mem_port_arbiter.md
Name: fiber_mem_port_arbiter

Overview:
- Shares the single-port 512x64 SRAM behind a fiber access tile between two requesters: the write path (buffet fill from the write scanner) and the read path (read scanner fetches).
- Issues at most one SRAM operation per cycle and holds write-burst fairness state.
- Returns read data through a credit-protected 2-entry response buffer, so read requesters see a plain valid/ready stream with no fixed-latency assumption.

Parameters:
- ADDR_W, 9, SRAM word address width
- DATA_W, 64, SRAM word width
- MAX_WR_BURST, 4, maximum consecutive write grants while a read is eligible (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  global enable; low freezes all state
- flush  in  1  synchronous clear of all state (same effect as reset)
- wr_req_valid  in  1  write request
- wr_req_addr  in  ADDR_W  write address
- wr_req_data  in  DATA_W  write data
- wr_req_ready  out  1  write granted this cycle
- rd_req_valid  in  1  read request
- rd_req_addr  in  ADDR_W  read address
- rd_req_ready  out  1  read granted this cycle
- rd_rsp_data  out  DATA_W  read return data
- rd_rsp_valid  out  1  response available
- rd_rsp_ready  in  1  response consumer ready
- addr_to_mem  out  ADDR_W  SRAM address
- data_to_mem  out  DATA_W  SRAM write data
- wen_to_mem  out  1  SRAM write enable
- ren_to_mem  out  1  SRAM read enable
- data_from_mem  in  DATA_W  SRAM read data, valid the cycle after ren_to_mem
- busy  out  1  in-flight read or non-empty response buffer

Behaviour:
- Reset/flush values:
  - State: pref=WR, wr_cnt=0, inflight=0, response buffer empty.
  - Outputs: all outputs 0; addr_to_mem and data_to_mem are 0.
- Eligibility:
  - occ = buf_count + inflight, range 0..2.
  - rd_el = rd_req_valid and clk_en and not flush and (occ<2 or (occ==2 and buf_count>0 and rd_rsp_valid and rd_rsp_ready)).
  - wr_el = wr_req_valid and clk_en and not flush.
- Grant:
  - Only one eligible: grant it.
  - Both eligible: grant pref.
  - Ready outputs are combinational from valid inputs and rd_rsp_ready. The request handshake equals the grant.
- Fairness FSM, pref ∈ {WR, RD}:
  - Write grant: wr_cnt := wr_cnt+1. If wr_cnt+1 == MAX_WR_BURST, then pref := RD and wr_cnt := 0.
  - Read grant: pref := WR, wr_cnt := 0.
  - No grant: hold.
  - Lone writes with no read pending still advance wr_cnt.
- SRAM drive, combinational from grant:
  - Write grant: wen=1, addr=wr_req_addr, data_to_mem=wr_req_data.
  - Read grant: ren=1, addr=rd_req_addr, data_to_mem=0.
  - Otherwise: all zero.
  - wen and ren are never both 1.
- Read return:
  - Latency: inflight := ren_to_mem each enabled cycle. When inflight is 1, data_from_mem is pushed into the buffer. Earliest rd_rsp_valid is the cycle after the grant +1 (2 cycles after rd_req handshake edge… i.e. grant in cycle N, push at end of N+1, valid in N+2).
  - Buffer: 2-entry FIFO, FWFT. Push and pop in the same cycle are legal at any count.
  - Overflow: the credit rule makes overflow impossible. An overflow reaching the buffer is an assertion failure.
- clk_en low:
  - No grants, readies 0, SRAM enables 0.
  - FIFO, inflight, pref and wr_cnt hold; no push or pop.
  - rd_rsp_valid still reflects buffer contents, but a pop is ignored. Consumers must qualify the pop with clk_en.
- flush while a read is in flight: the in-flight data is discarded and not pushed.
- Async reset mid-operation: state clears immediately. A request pending across reset is re-arbitrated from pref=WR.

Decomposition:
- Package fiber_mem_arb_pkg:
  - grant_t enum {GNT_NONE, GNT_WR, GNT_RD}
  - pref_t enum {PREF_WR, PREF_RD}
  - RSP_DEPTH=2
- One sub-module, fiber_mem_arb_rsp_fifo: 2-entry FWFT FIFO with count output, clk_en and flush.
- The arbiter top holds the FSM, the credit check and the SRAM mux.

Test Plan:
- Write only: 6 writes to addr 0..5, data 0xA0..0xA5 → wen pulses 6 consecutive cycles with matching addr/data. wr_cnt wraps at 4; ren never asserted.
- Read after write: after the writes above, read addr 3 with rd_rsp_ready=1 → ren in cycle N with addr 3; rd_rsp_valid=1, data 0xA3 in N+2; busy drops in N+3.
- Contention with both valid continuously, MAX_WR_BURST=4, sink always ready → grant pattern W,W,W,W,R,W,W,W,W,R…
- Backpressure: rd_rsp_ready=0, 4 reads requested → exactly 2 granted, then rd_req_ready=0. Release ready → the remaining reads issue; data order matches address order, nothing lost or duplicated.
- flush at cycle N+1 after a read grant in N → no push, rd_rsp_valid stays 0, pref=WR, next contention grants write.
- clk_en=0 for 3 cycles with both valid and buffer holding 1 entry → no SRAM enables, buffer count unchanged. Arbitration resumes with the same pref afterwards.
